text_render_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational text colour mapper.
- Converts a pixel coordinate stream into RGB. Internally it:
  - computes the character-cell VRAM address,
  - fetches the glyph row through a synchronous font ROM port,
  - resolves foreground/background through a flat palette,
  - overlays a blinking hardware cursor.
- Sits between the VGA/HDMI timing generator and the TMDS encoder inside the HDMI text controller IP, driving the VRAM read port and the font ROM.

---
 rtl/text_render_pipe.sv | 151 +++++++++++++++
 tb/tb_text_render_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/text_render_pipe.sv
// Pipelined text-mode renderer: pixel coordinate -> VRAM word -> font row -> palette RGB, fixed 3-cycle latency.
// Optional build macro TEXT_BLINK_EN turns bg index bit 3 into a per-character blink attribute.
module text_render_pipe #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int COLOR_W      = 4,
  parameter int PAL_N        = 16,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          in_valid,
  input  logic [9:0]                    draw_x,
  input  logic [9:0]                    draw_y,
  input  logic                          frame_start,
  output logic [$clog2(COLS*ROWS)-1:0]  vram_addr,
  input  logic [15:0]                   vram_rdata,
  output logic [7+$clog2(CHAR_H)-1:0]   font_addr,
  input  logic [CHAR_W-1:0]             font_data,
  input  logic [PAL_N*3*COLOR_W-1:0]    palette,
  input  logic                          cursor_en,
  input  logic [$clog2(COLS)-1:0]       cursor_col,
  input  logic [$clog2(ROWS)-1:0]       cursor_row,
  output logic                          out_valid,
  output logic [COLOR_W-1:0]            red,
  output logic [COLOR_W-1:0]            green,
  output logic [COLOR_W-1:0]            blue
);

  localparam int XS   = $clog2(CHAR_W);
  localparam int YS   = $clog2(CHAR_H);
  localparam int VA_W = $clog2(COLS*ROWS);
  localparam int ENT  = 3*COLOR_W;
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Cycle N: cell coordinates by shifting, address is purely combinational
  logic [9:0] cell_col, cell_row;
  logic       active, cursor_hit;

  assign cell_col   = draw_x >> XS;
  assign cell_row   = draw_y >> YS;
  assign vram_addr  = VA_W'(cell_row) * VA_W'(COLS) + VA_W'(cell_col);
  assign active     = ({22'd0, draw_x} < 32'(COLS*CHAR_W)) && ({22'd0, draw_y} < 32'(ROWS*CHAR_H));
  assign cursor_hit = (cell_col == 10'(cursor_col)) && (cell_row == 10'(cursor_row));

  // Blink counter
  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES-1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage registers
  logic          s1_valid_q, s1_active_q, s1_cursor_q;
  logic [XS-1:0] s1_subx_q;
  logic [YS-1:0] s1_suby_q;
  logic          s2_valid_q, s2_active_q, s2_cursor_q, s2_inv_q;
  logic [XS-1:0] s2_subx_q;
  logic [3:0]    s2_fg_q, s2_bg_q;
`ifdef TEXT_BLINK_EN
  logic          s1_phase_q, s2_phase_q;
`endif
  logic          out_valid_q;
  logic [ENT-1:0] rgb_q, rgb_d;

  // Cycle N+1: glyph row address from the fetched character word
  assign font_addr = {vram_rdata[14:8], s1_suby_q};

  // Cycle N+2: pixel select, invert/cursor XOR, palette lookup
  logic       pix, lit;
  logic [3:0] bg_sel, pal_sel;

  always_comb begin
    pix    = font_data[~s2_subx_q];
    lit    = pix ^ s2_inv_q ^ s2_cursor_q;
    bg_sel = s2_bg_q;
`ifdef TEXT_BLINK_EN
    bg_sel = {1'b0, s2_bg_q[2:0]};
    if (s2_bg_q[3] && !s2_phase_q) lit = 1'b0;
`endif
    pal_sel = lit ? s2_fg_q : bg_sel;
    rgb_d   = '0;
    if (s2_valid_q && s2_active_q) rgb_d = palette[int'(pal_sel)*ENT +: ENT];
  end

  always_ff @(posedge axi_aclk) begin
    // NOTE: synchronous reset clears data registers as well as valids, so RGB reads 0 straight out of reset.
    if (!axi_aresetn) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      s1_valid_q    <= 1'b0;
      s1_active_q   <= 1'b0;
      s1_cursor_q   <= 1'b0;
      s1_subx_q     <= '0;
      s1_suby_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_active_q   <= 1'b0;
      s2_cursor_q   <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_subx_q     <= '0;
      s2_fg_q       <= '0;
      s2_bg_q       <= '0;
`ifdef TEXT_BLINK_EN
      s1_phase_q    <= 1'b1;
      s2_phase_q    <= 1'b1;
`endif
      out_valid_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      // Phase is captured at sample time so a coincident frame_start only affects later pixels
      s1_valid_q    <= in_valid;
      s1_active_q   <= active;
      s1_cursor_q   <= cursor_hit & cursor_en & blink_phase_q;
      s1_subx_q     <= draw_x[XS-1:0];
      s1_suby_q     <= draw_y[YS-1:0];
      s2_valid_q    <= s1_valid_q;
      s2_active_q   <= s1_active_q;
      s2_cursor_q   <= s1_cursor_q;
      s2_inv_q      <= vram_rdata[15];
      s2_subx_q     <= s1_subx_q;
      s2_fg_q       <= vram_rdata[7:4];
      s2_bg_q       <= vram_rdata[3:0];
`ifdef TEXT_BLINK_EN
      s1_phase_q    <= blink_phase_q;
      s2_phase_q    <= s1_phase_q;
`endif
      out_valid_q   <= s2_valid_q;
      rgb_q         <= rgb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign red       = rgb_q[ENT-1 -: COLOR_W];
  assign green     = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue      = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_text_render_pipe.sv
// Directed bench for text_render_pipe: VRAM and font ROM modelled as synchronous-read arrays, BLINK_FRAMES=2.
module tb_text_render_pipe;

  localparam int COLS = 80, ROWS = 30, CHAR_W = 8, CHAR_H = 16;
  localparam int COLOR_W = 4, PAL_N = 16, BLINK_FRAMES = 2;

  // Palette entry i = {R=i, G=15-i, B=i+3}
  localparam logic [11:0] PAL0 = 12'h0F3;
  localparam logic [11:0] PAL1 = 12'h1E4;
  localparam logic [11:0] PAL2 = 12'h2D5;
  localparam logic [11:0] PAL4 = 12'h4B7;

  logic        clk = 1'b0;
  logic        axi_aresetn;
  logic        in_valid;
  logic [9:0]  draw_x, draw_y;
  logic        frame_start;
  logic [11:0] vram_addr;
  logic [15:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [PAL_N*3*COLOR_W-1:0] palette;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        out_valid;
  logic [3:0]  red, green, blue;

  logic [15:0] vram [0:4095];
  logic [7:0]  font [0:2047];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  text_render_pipe #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
    .COLOR_W(COLOR_W), .PAL_N(PAL_N), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn), .in_valid(in_valid),
    .draw_x(draw_x), .draw_y(draw_y), .frame_start(frame_start),
    .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .font_addr(font_addr), .font_data(font_data), .palette(palette),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue)
  );

  always @(posedge clk) begin
    vram_rdata <= vram[vram_addr];
    font_data  <= font[font_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated pixel: checks latency is exactly 3 and the colour it lands with
  task automatic pixel(input int x, input int y, input logic fs, input logic [11:0] exp_rgb,
                       input logic chk_addr, input logic [11:0] exp_va, input logic [10:0] exp_fa,
                       input string tag);
    @(negedge clk);
    in_valid = 1'b1; draw_x = 10'(x); draw_y = 10'(y); frame_start = fs;
    #1;
    if (chk_addr) check({tag, " vram_addr"}, 32'(vram_addr), 32'(exp_va));
    @(negedge clk);
    if (chk_addr) check({tag, " font_addr"}, 32'(font_addr), 32'(exp_fa));
    in_valid = 1'b0; frame_start = 1'b0;
    check({tag, " valid@1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid@2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid@3"}, 32'(out_valid), 32'd1);
    check({tag, " rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) vram[i] = 16'h0000;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    palette = '0;
    for (int i = 0; i < PAL_N; i++) palette[i*12 +: 12] = {4'(i), 4'(15-i), 4'(i+3)};
    for (int c = 0; c < COLS; c++) vram[c] = 16'h0141;
    font[11'h010] = 8'h80;
    vram[162]     = 16'h0223;
    font[11'h023] = 8'h20;

    axi_aresetn = 1'b0; in_valid = 1'b0; draw_x = '0; draw_y = '0; frame_start = 1'b0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    repeat (3) @(negedge clk);
    axi_aresetn = 1'b1;
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset rgb", 32'({red, green, blue}), 32'd0);

    // Single pixel at (0,0): glyph 1 -> font_addr 0x10, bit 7 set -> fg 4
    pixel(0, 0, 1'b0, PAL4, 1'b1, 12'd0, 11'h010, "single");
    // (18,35): cell (2,2) -> addr 162, glyph 2 row 3 -> 0x23, sub_x 2 -> bit 5 set -> fg 2
    pixel(18, 35, 1'b0, PAL2, 1'b1, 12'd162, 11'h023, "cell22");
    // Same cell, sub_x 1 -> bit 6 clear -> bg 3
    pixel(17, 35, 1'b0, 12'h3C6, 1'b0, 12'd0, 11'd0, "cell22bg");

    // Invert and cursor cancel each other at the cursor cell
    vram[0] = 16'h8141; cursor_en = 1'b1;
    pixel(0, 0, 1'b0, PAL4, 1'b0, 12'd0, 11'd0, "invcur x0");
    pixel(1, 0, 1'b0, PAL1, 1'b0, 12'd0, 11'd0, "invcur x1");
    // Invert alone flips the pixel
    cursor_en = 1'b0;
    pixel(0, 0, 1'b0, PAL1, 1'b0, 12'd0, 11'd0, "inv x0");
    vram[0] = 16'h0141;

    // Full-rate row 0: no bubbles, colour pattern repeats every 8 pixels
    for (int k = 0; k < 643; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        check($sformatf("stream valid p%0d", k-3), 32'(out_valid), 32'd1);
        check($sformatf("stream rgb p%0d", k-3), 32'({red, green, blue}),
              32'(((k-3) % 8 == 0) ? PAL4 : PAL1));
      end
      if (k < 640) begin
        in_valid = 1'b1; draw_x = 10'(k); draw_y = 10'd0;
        #1;
        if (k % 8 == 0) check($sformatf("stream vram_addr x%0d", k), 32'(vram_addr), 32'(k / 8));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stream tail valid", 32'(out_valid), 32'd0);

    // Outside the active area: valid still follows, colour forced to 0
    pixel(700, 0, 1'b0, 12'h000, 1'b0, 12'd0, 11'd0, "oob x700");
    pixel(640, 0, 1'b0, 12'h000, 1'b0, 12'd0, 11'd0, "oob x640");
    pixel(0, 480, 1'b0, 12'h000, 1'b0, 12'd0, 11'd0, "oob y480");
    pixel(639, 479, 1'b0, PAL0, 1'b0, 12'd0, 11'd0, "edge 639,479");

    // Cursor blink with BLINK_FRAMES=2; x=1 glyph pixel is 0 so cursor alone lights it
    cursor_en = 1'b1;
    pixel(1, 0, 1'b0, PAL4, 1'b0, 12'd0, 11'd0, "blink f0");
    pulse_frame();
    pixel(1, 0, 1'b0, PAL4, 1'b0, 12'd0, 11'd0, "blink f1");
    pulse_frame();
    pixel(1, 0, 1'b0, PAL1, 1'b0, 12'd0, 11'd0, "blink f2");
    pulse_frame();
    pixel(1, 0, 1'b1, PAL1, 1'b0, 12'd0, 11'd0, "blink coincident");
    pixel(1, 0, 1'b0, PAL4, 1'b0, 12'd0, 11'd0, "blink after");
    pulse_frame();
    pulse_frame();
    pixel(1, 0, 1'b0, PAL1, 1'b0, 12'd0, 11'd0, "blink off again");

    // Mid-stream reset drops three in-flight pixels and restores blink_phase=1
    @(negedge clk); in_valid = 1'b1; draw_x = 10'd0; draw_y = 10'd0;
    @(negedge clk); draw_x = 10'd1;
    check("midrst pre valid", 32'(out_valid), 32'd0);
    @(negedge clk); draw_x = 10'd2; axi_aresetn = 1'b0;
    @(negedge clk); axi_aresetn = 1'b1; in_valid = 1'b0;
    check("midrst drop0", 32'(out_valid), 32'd0);
    check("midrst rgb0", 32'({red, green, blue}), 32'd0);
    @(negedge clk);
    check("midrst drop1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("midrst drop2", 32'(out_valid), 32'd0);
    pixel(1, 0, 1'b0, PAL4, 1'b0, 12'd0, 11'd0, "after midrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
